// File: rtl/ham_8_4_scrub_ctrl.sv
// ham_8_4_scrub_ctrl
//   Sequences an external combinational SECDED Hamming(8,4) decoder/encoder
//   pair over a 4-bit-data / 8-bit-codeword SRAM. Host reads are arbitrated
//   against a periodic background scrubber. Corrected words can be written
//   back, and corrected/uncorrectable error counts are kept.
//
//   Build option: define HAM_SCRUB_WRITEBACK_EN to enable the writeback
//   state (WB). Without it, corrected words are reported and counted but
//   never rewritten, and mem_we is tied low.
//
// Ports
//   clk, rst       clock (rising edge) and synchronous active-high reset
//   host_req       host read request, held until host_gnt
//   host_addr      host read address, sampled on host_gnt
//   host_gnt       grant (combinational, IDLE and host wins arbitration)
//   host_rvalid    one-cycle pulse with host_rdata / host_rerr
//   host_rdata     corrected data
//   host_rerr      decoder status: 0 clean, 1 corrected, 2/3 uncorrectable
//   mem_en/we      SRAM strobe / write enable; read data one cycle later
//   mem_addr       SRAM address
//   mem_wdata      SRAM write codeword (encoder output)
//   mem_rdata      SRAM read codeword
//   dec_code       registered codeword driven to the decoder
//   dec_data/err   decoder outputs
//   enc_data       encoder input (decoder corrected data)
//   enc_code       encoder output
//   ce_cnt/ue_cnt  saturating corrected / uncorrectable counts
//   scrub_addr     next address the scrubber will visit
//   busy           FSM not in IDLE
module ham_8_4_scrub_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [3:0]        host_rdata,
  output logic [1:0]        host_rerr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        dec_code,
  input  logic [3:0]        dec_data,
  input  logic [1:0]        dec_err,
  output logic [3:0]        enc_data,
  input  logic [7:0]        enc_code,
  output logic [15:0]       ce_cnt,
  output logic [15:0]       ue_cnt,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic              busy
);

  localparam int TMR_W = $clog2(SCRUB_INTERVAL);
  localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  logic [2:0]        state;
  logic              op_host;
  logic [ADDR_W-1:0] op_addr;
  logic [TMR_W-1:0]  tmr;
  logic              scrub_pend;
  logic              last_host;

  logic idle, host_win, scrub_go, tmr_exp;
  logic err_fix, err_ue, do_wb, scrub_end;

  assign idle     = (state == S_IDLE);
  // A pending scrub that already lost to the host once wins the next slot.
  assign host_win = host_req && !(scrub_pend && last_host);
  assign host_gnt = idle && host_win;
  assign scrub_go = idle && !host_win && scrub_pend;
  assign tmr_exp  = (tmr == '0);

  assign err_fix = (dec_err == 2'd1);
  assign err_ue  = dec_err[1];

`ifdef HAM_SCRUB_WRITEBACK_EN
  assign do_wb  = err_fix;
  assign mem_we = (state == S_WB);
`else
  assign do_wb  = 1'b0;
  assign mem_we = 1'b0;
`endif

  // Scrub op finishes either straight out of CHK or after its writeback.
  assign scrub_end = !op_host && ((state == S_CHK && !do_wb) || state == S_WB);

  assign busy        = !idle;
  assign host_rvalid = (state == S_CHK) && op_host;
  assign host_rdata  = host_rvalid ? dec_data : 4'h0;
  assign host_rerr   = host_rvalid ? dec_err  : 2'd0;

  assign mem_en    = (state == S_RD) || (state == S_WB);
  assign mem_addr  = mem_en ? op_addr : '0;
  // dec_code still holds the faulty word in WB, so the encoder sees the
  // corrected data there without any extra capture register.
  assign enc_data  = dec_data;
  assign mem_wdata = enc_code;

  // Scrub request timer; an expiry in the same cycle as a scrub start
  // wins over the clear so that request is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr        <= TMR_RELOAD;
      scrub_pend <= 1'b0;
    end else begin
      tmr <= tmr_exp ? TMR_RELOAD : tmr - 1'b1;
      if (tmr_exp)       scrub_pend <= 1'b1;
      else if (scrub_go) scrub_pend <= 1'b0;
    end
  end

  // Main sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_host   <= 1'b0;
      op_addr   <= '0;
      last_host <= 1'b0;
      dec_code  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_gnt) begin
            state     <= S_RD;
            op_host   <= 1'b1;
            op_addr   <= host_addr;
            last_host <= 1'b1;
          end else if (scrub_go) begin
            state     <= S_RD;
            op_host   <= 1'b0;
            op_addr   <= scrub_addr;
            last_host <= 1'b0;
          end
        end
        S_RD:   state <= S_WAIT;
        S_WAIT: begin
          dec_code <= mem_rdata;
          state    <= S_CHK;
        end
        S_CHK:  state <= do_wb ? S_WB : S_IDLE;
        S_WB:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Error statistics, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_cnt <= 16'h0000;
      ue_cnt <= 16'h0000;
    end else if (state == S_CHK) begin
      if (err_fix && ce_cnt != 16'hFFFF) ce_cnt <= ce_cnt + 16'h0001;
      if (err_ue  && ue_cnt != 16'hFFFF) ue_cnt <= ue_cnt + 16'h0001;
    end
  end

  // Scrub pointer advances only when a scrub op completes
  always_ff @(posedge clk) begin
    if (rst) begin
      scrub_addr <= '0;
    end else if (scrub_end) begin
      scrub_addr <= (scrub_addr == LAST_ADDR) ? '0 : scrub_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_ham_8_4_scrub_ctrl.sv
module tb_ham_8_4_scrub_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Hamming(8,4) SECDED environment model: code[7:1] are positions 1..7
  // (p1 p2 d0 p4 d1 d2 d3), code[0] is overall parity.
  function automatic logic [7:0] enc_f(input logic [3:0] d);
    logic [7:0] c;
    c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic logic [5:0] dec_f(input logic [7:0] c);
    logic [2:0] s;
    logic [7:0] f;
    logic [1:0] e;
    s[0] = c[1] ^ c[3] ^ c[5] ^ c[7];
    s[1] = c[2] ^ c[3] ^ c[6] ^ c[7];
    s[2] = c[4] ^ c[5] ^ c[6] ^ c[7];
    f = c;
    e = 2'd0;
    if (^c) begin
      e = 2'd1;
      f[s] = ~f[s];
    end else if (s != 3'd0) begin
      e = 2'd2;
    end
    return {e, f[7], f[6], f[5], f[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: default parameters ----------------
  logic       a_rst, a_host_req, a_host_gnt, a_host_rvalid;
  logic [7:0] a_host_addr;
  logic [3:0] a_host_rdata, a_dec_data, a_enc_data;
  logic [1:0] a_host_rerr, a_dec_err;
  logic       a_mem_en, a_mem_we, a_busy;
  logic [7:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_dec_code, a_enc_code, a_scrub_addr;
  logic [15:0] a_ce_cnt, a_ue_cnt;
  logic [7:0] mem_a [256];
  int a_we_cnt = 0;

  assign {a_dec_err, a_dec_data} = dec_f(a_dec_code);
  assign a_enc_code = enc_f(a_enc_data);

  ham_8_4_scrub_ctrl u_dut (
    .clk(clk), .rst(a_rst),
    .host_req(a_host_req), .host_addr(a_host_addr), .host_gnt(a_host_gnt),
    .host_rvalid(a_host_rvalid), .host_rdata(a_host_rdata), .host_rerr(a_host_rerr),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .dec_code(a_dec_code), .dec_data(a_dec_data), .dec_err(a_dec_err),
    .enc_data(a_enc_data), .enc_code(a_enc_code),
    .ce_cnt(a_ce_cnt), .ue_cnt(a_ue_cnt), .scrub_addr(a_scrub_addr), .busy(a_busy)
  );

  // SRAM A: clean 8'hA5 (= enc 4'hA) everywhere, addr 7 = enc(3)^bit5, addr 9 = enc(3)^2'b11
  always @(posedge clk) begin
    if (a_rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'hA5;
      mem_a[7] <= 8'h1C;
      mem_a[9] <= 8'h3F;
    end else if (a_mem_en) begin
      if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
      else          a_mem_rdata       <= mem_a[a_mem_addr];
    end
    if (a_mem_en && a_mem_we) a_we_cnt <= a_we_cnt + 1;
  end

  // ---------------- instance B: DEPTH=4, SCRUB_INTERVAL=4 ----------------
  logic       b_rst, b_host_req, b_host_gnt, b_host_rvalid;
  logic [7:0] b_host_addr;
  logic [3:0] b_host_rdata, b_dec_data, b_enc_data;
  logic [1:0] b_host_rerr, b_dec_err;
  logic       b_mem_en, b_mem_we, b_busy;
  logic [7:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_dec_code, b_enc_code, b_scrub_addr;
  logic [15:0] b_ce_cnt, b_ue_cnt;
  logic [7:0] mem_b [256];
  logic [7:0] b_reads [$];
  int b_rv_cnt = 0;

  assign {b_dec_err, b_dec_data} = dec_f(b_dec_code);
  assign b_enc_code = enc_f(b_enc_data);

  ham_8_4_scrub_ctrl #(.ADDR_W(8), .DEPTH(4), .SCRUB_INTERVAL(4)) u_scr (
    .clk(clk), .rst(b_rst),
    .host_req(b_host_req), .host_addr(b_host_addr), .host_gnt(b_host_gnt),
    .host_rvalid(b_host_rvalid), .host_rdata(b_host_rdata), .host_rerr(b_host_rerr),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .dec_code(b_dec_code), .dec_data(b_dec_data), .dec_err(b_dec_err),
    .enc_data(b_enc_data), .enc_code(b_enc_code),
    .ce_cnt(b_ce_cnt), .ue_cnt(b_ue_cnt), .scrub_addr(b_scrub_addr), .busy(b_busy)
  );

  always @(posedge clk) begin
    if (b_rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'hA5;
    end else if (b_mem_en) begin
      if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
      else          b_mem_rdata       <= mem_b[b_mem_addr];
    end
    if (!b_rst && b_mem_en && !b_mem_we) b_reads.push_back(b_mem_addr);
    if (!b_rst && b_host_rvalid) b_rv_cnt <= b_rv_cnt + 1;
  end

  // Host read on instance A starting at a negedge (cycle T, IDLE);
  // returns at the negedge of cycle T+3 after the rvalid checks.
  task automatic do_read(input logic [7:0] addr, input logic [3:0] exp_d, input logic [1:0] exp_e);
    a_host_req  = 1'b1;
    a_host_addr = addr;
    #1 check("gnt_T", 32'(a_host_gnt), 32'd1);
    @(negedge clk);
    a_host_req = 1'b0;
    check("rd_en", 32'({a_mem_en, a_mem_we}), 32'b10);
    check("rd_addr", 32'(a_mem_addr), 32'(addr));
    @(negedge clk);
    check("rvalid_T2", 32'(a_host_rvalid), 32'd0);
    @(negedge clk);
    check("rvalid_T3", 32'(a_host_rvalid), 32'd1);
    check("rdata", 32'(a_host_rdata), 32'(exp_d));
    check("rerr", 32'(a_host_rerr), 32'(exp_e));
  endtask

  logic [7:0] exp_rd [10];
  int we_before;
  int wait_cyc;

  initial begin
    a_rst = 1'b1; a_host_req = 1'b0; a_host_addr = 8'h00;
    b_rst = 1'b1; b_host_req = 1'b0; b_host_addr = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_rvalid", 32'(a_host_rvalid), 32'd0);
    check("rst_mem", 32'({a_mem_en, a_mem_we}), 32'd0);
    check("rst_cnt", {a_ce_cnt, a_ue_cnt}, 32'd0);
    check("rst_scrub", 32'(a_scrub_addr), 32'd0);
    check("rst_dec", 32'(a_dec_code), 32'd0);
    a_rst = 1'b0;
    @(negedge clk);

    // Clean word
    do_read(8'd5, 4'hA, 2'd0);
    @(negedge clk);
    check("clean_idle", 32'(a_busy), 32'd0);
    check("clean_we", 32'(a_we_cnt), 32'd0);
    check("clean_cnt", {a_ce_cnt, a_ue_cnt}, 32'd0);

    // Single-bit error
    do_read(8'd7, 4'h3, 2'd1);
    @(negedge clk);  // T+4
    check("ce_cnt1", 32'(a_ce_cnt), 32'd1);
`ifdef HAM_SCRUB_WRITEBACK_EN
    check("wb_strobe", 32'({a_mem_en, a_mem_we}), 32'b11);
    check("wb_addr", 32'(a_mem_addr), 32'd7);
    check("wb_data", 32'(a_mem_wdata), 32'h3C);
    a_host_req = 1'b1; a_host_addr = 8'd9;
    #1 check("gnt_in_wb", 32'(a_host_gnt), 32'd0);
    @(negedge clk);
    check("mem7_fixed", 32'(mem_a[7]), 32'h3C);
`else
    check("nowb_we", 32'(a_mem_we), 32'd0);
    check("nowb_busy", 32'(a_busy), 32'd0);
`endif

    // Double-bit error (granted at T+4 when writeback is off)
    do_read(8'd9, 4'h3, 2'd2);
    @(negedge clk);
    check("ue_cnt1", 32'(a_ue_cnt), 32'd1);
    check("ce_hold", 32'(a_ce_cnt), 32'd1);
`ifdef HAM_SCRUB_WRITEBACK_EN
    check("ue_no_wb", 32'(a_we_cnt), 32'd1);
`else
    check("ue_no_wb", 32'(a_we_cnt), 32'd0);
`endif

    // Reset in WAIT aborts the op
    we_before = a_we_cnt;
    a_host_req = 1'b1; a_host_addr = 8'd7;
    @(negedge clk);
    a_host_req = 1'b0;
    @(negedge clk);  // WAIT
    a_rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_rvalid", 32'(a_host_rvalid), 32'd0);
    check("abort_cnt", {a_ce_cnt, a_ue_cnt}, 32'd0);
    a_rst = 1'b0;
    @(negedge clk);
    check("abort_rvalid2", 32'(a_host_rvalid), 32'd0);
    check("abort_idle", 32'(a_busy), 32'd0);
    check("abort_we", 32'(a_we_cnt), 32'(we_before));

    // Scrub/host alternation on the small instance
    exp_rd = '{8'h10, 8'h0, 8'h10, 8'h1, 8'h10, 8'h2, 8'h10, 8'h3, 8'h10, 8'h0};
    b_host_req  = 1'b1;
    b_host_addr = 8'h10;
    b_rst = 1'b0;
    wait_cyc = 0;
    while (b_reads.size() < 10 && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("scrub_timeout", 32'(b_reads.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < b_reads.size()) check($sformatf("alt_rd%0d", i), 32'(b_reads[i]), 32'(exp_rd[i]));
    end
    check("alt_rvalids", 32'(b_rv_cnt >= 4), 32'd1);
    check("alt_clean", {b_ce_cnt, b_ue_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
